// File: rtl/ped_req_pkg.sv
// Shared definitions for the pedestrian request unit: state encoding,
// default parameter values and the served-request counter width.
package ped_req_pkg;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefTimeoutCycles  = 64;
  localparam int unsigned DefHoldoffCycles  = 8;
  localparam int unsigned DefCntW           = 8;
  localparam int unsigned ReqCountW         = 16;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDebounce = 3'd1,
    StReq      = 3'd2,
    StGrant    = 3'd3,
    StHoldoff  = 3'd4
  } ped_state_e;

endpackage

// File: rtl/ped_btn_sync.sv
// Button input conditioning: 2-flop synchroniser for the asynchronous raw
// push-button plus the 'armed' tracker that blocks a held button from
// raising more than one request.
module ped_btn_sync
  import ped_req_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  input  logic req_entry,
  output logic btn_s,
  output logic armed
);

  logic sync1_q, sync2_q;
  logic armed_q, armed_d;

  // Release re-arms; entering REQ disarms until the button is let go.
  always_comb begin
    armed_d = armed_q;
    if (!sync2_q) begin
      armed_d = 1'b1;
    end else if (req_entry) begin
      armed_d = 1'b0;
    end
  end

  // Synchroniser flops and armed flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      armed_q <= armed_d;
    end
  end

  assign btn_s = sync2_q;
  assign armed = armed_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request initiator: debounces the push-button into a held 'key'
// request, drops it once the controller serves it (green then red) or after
// a timeout, and ignores presses for a hold-off window after the green phase.
// Optional build macro PED_REQ_COUNT_EN adds a saturating served-request
// counter output 'req_count'.
module ped_request_unit
  import ped_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
  parameter int unsigned HOLDOFF_CYCLES  = DefHoldoffCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  input  logic red,
  input  logic green,
  output logic key,
  output logic wait_lamp,
  output logic timeout,
  output logic lamp_fault
`ifdef PED_REQ_COUNT_EN
  ,
  output logic [ReqCountW-1:0] req_count
`endif
);

  localparam logic [CNT_W-1:0] DebLoad  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TmoLoad  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic btn_s, armed, req_entry;
  logic lamp_grant, lamp_release, lamp_bad;
  logic key_d, wait_d, timeout_d, fault_d;
  logic key_q, wait_q, timeout_q, fault_q;

  ped_btn_sync u_btn_sync (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .req_entry (req_entry),
    .btn_s     (btn_s),
    .armed     (armed)
  );

  // Only the two clean lamp combinations mean anything; equal lamps are a fault.
  assign lamp_grant   = green & ~red;
  assign lamp_release = red & ~green;
  assign lamp_bad     = (red == green);

  // State and shared down-counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter; the counter is reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (btn_s && armed) begin
          state_d = StDebounce;
          cnt_d   = DebLoad;
        end
      end
      StDebounce: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StReq;
          cnt_d   = TmoLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StReq: begin
        // Grant wins over a coincident timeout.
        if (lamp_grant) begin
          state_d = StGrant;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StGrant: begin
        if (lamp_release) begin
          state_d = StHoldoff;
          cnt_d   = HoldLoad;
        end
      end
      StHoldoff: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    key_d     = (state_d == StReq);
    wait_d    = (state_d == StReq);
    timeout_d = (state_q == StReq) && !lamp_grant && (cnt_q == '0);
    fault_d   = ((state_q == StReq) || (state_q == StGrant)) && lamp_bad;
    req_entry = (state_d == StReq) && (state_q != StReq);
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q     <= 1'b0;
      wait_q    <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      key_q     <= key_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
    end
  end

  assign key        = key_q;
  assign wait_lamp  = wait_q;
  assign timeout    = timeout_q;
  assign lamp_fault = fault_q;

`ifdef PED_REQ_COUNT_EN
  logic                 grant_evt;
  logic [ReqCountW-1:0] req_count_q;

  assign grant_evt = (state_q == StReq) && lamp_grant;

  // Saturating count of served requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_count_q <= '0;
    end else if (grant_evt && (req_count_q != '1)) begin
      req_count_q <= req_count_q + ReqCountW'(1);
    end
  end

  assign req_count = req_count_q;
`endif

endmodule

// File: tb/tb_ped_request_unit.sv
// Bench for ped_request_unit: directed scenarios plus randomized button and
// lamp traffic, every cycle compared against a behavioural model.
module tb_ped_request_unit;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Tmo  = 64;
  localparam int unsigned Hold = 8;

  logic clock = 1'b0;
  logic reset, btn_raw, red, green;
  logic key, wait_lamp, timeout, lamp_fault;
`ifdef PED_REQ_COUNT_EN
  logic [15:0] req_count;
`endif

  always #5 clock = ~clock;

  ped_request_unit #(
    .DEBOUNCE_CYCLES (Deb),
    .TIMEOUT_CYCLES  (Tmo),
    .HOLDOFF_CYCLES  (Hold),
    .CNT_W           (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .red        (red),
    .green      (green),
    .key        (key),
    .wait_lamp  (wait_lamp),
    .timeout    (timeout),
    .lamp_fault (lamp_fault)
`ifdef PED_REQ_COUNT_EN
    ,
    .req_count  (req_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phases of a request and cycles remaining in the phase.
  localparam int PhIdle = 0, PhDeb = 1, PhReq = 2, PhGrant = 3, PhHold = 4;
  bit m_s1, m_s2, m_armed;
  int m_phase, m_left, m_served;
  bit m_key, m_to, m_lf;

  task automatic model_step();
    bit bs, entered;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_armed = 1; m_phase = PhIdle; m_left = 0;
      m_key = 0; m_to = 0; m_lf = 0; m_served = 0;
      return;
    end
    bs = m_s2;
    entered = 0;
    m_to = 0;
    m_lf = ((m_phase == PhReq) || (m_phase == PhGrant)) && (red == green);
    case (m_phase)
      PhIdle: if (bs && m_armed) begin m_phase = PhDeb; m_left = Deb - 1; end
      PhDeb: begin
        if (!bs) m_phase = PhIdle;
        else if (m_left == 0) begin m_phase = PhReq; m_left = Tmo - 1; entered = 1; end
        else m_left--;
      end
      PhReq: begin
        if (green && !red) begin
          m_phase = PhGrant;
          if (m_served < 65535) m_served++;
        end else if (m_left == 0) begin
          m_to = 1; m_phase = PhIdle;
        end else m_left--;
      end
      PhGrant: if (red && !green) begin m_phase = PhHold; m_left = Hold - 1; end
      default: if (m_left == 0) m_phase = PhIdle; else m_left--;
    endcase
    if (!bs) m_armed = 1;
    else if (entered) m_armed = 0;
    m_s2 = m_s1;
    m_s1 = btn_raw;
    m_key = (m_phase == PhReq);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("key", key, m_key);
    check("wait_lamp", wait_lamp, m_key);
    check("timeout", timeout, m_to);
    check("lamp_fault", lamp_fault, m_lf);
`ifdef PED_REQ_COUNT_EN
    check("req_count", req_count, m_served);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Cycles from the press edge until key is seen high; -1 if the budget expires.
  task automatic wait_rise(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (key) begin n = i; break; end
    end
  endtask

  task automatic serve_one();
    int lat;
    btn_raw = 1;
    wait_rise(lat);
    check("serve_latency", lat, Deb + 3);
    btn_raw = 0; green = 1; red = 0;
    ticks(3);
    red = 1; green = 0;
    ticks(Hold + 4);
  endtask

  initial begin
    int lat, n_key, n_to, n_lf;
    int btn_hold, lamp_hold, pick;

    reset = 1; btn_raw = 0; red = 1; green = 0;
    ticks(2);
    check("rst_key", key, 0);
    check("rst_wait", wait_lamp, 0);
    reset = 0;
    ticks(2);

    // Clean press, served by the controller, button still held afterwards.
    btn_raw = 1;
    wait_rise(lat);
    check("press_latency", lat, 7);
    check("press_wait", wait_lamp, 1);
    ticks(13);
    green = 1; red = 0;
    tick();
    check("grant_key", key, 0);
    ticks(9);
    red = 1; green = 0;
    n_key = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (key) n_key++; end
    check("held_no_rereq", n_key, 0);

    // Release, re-press, then let it time out.
    btn_raw = 0;
    ticks(4);
    btn_raw = 1;
    wait_rise(lat);
    check("rearm_latency", lat, 7);
    n_key = 1; n_to = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (key) n_key++;
      if (timeout) n_to++;
    end
    check("timeout_key_cycles", n_key, Tmo);
    check("timeout_pulses", n_to, 1);
    btn_raw = 0;
    ticks(4);
    btn_raw = 1;
    wait_rise(lat);
    check("repress_latency", lat, 7);

    // Lamp fault in REQ, then in GRANT.
    red = 1; green = 1;
    n_lf = 0; n_key = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (lamp_fault) n_lf++;
      if (key) n_key++;
    end
    check("req_fault_cycles", n_lf, 3);
    check("req_fault_key", n_key, 3);
    red = 0; green = 1;
    tick();
    check("fault_grant_key", key, 0);
    red = 0; green = 0;
    n_lf = 0;
    for (int i = 0; i < 2; i++) begin tick(); if (lamp_fault) n_lf++; end
    check("grant_fault_cycles", n_lf, 2);
    red = 1; green = 0;
    ticks(Hold + 4);

    // Bounce: single-cycle pulses never reach REQ.
    btn_raw = 0;
    ticks(4);
    btn_raw = 1; tick();
    btn_raw = 0; tick();
    btn_raw = 1; tick();
    btn_raw = 0;
    n_key = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (key) n_key++; end
    check("bounce_key", n_key, 0);

    // Reset while a request is pending.
    btn_raw = 1;
    wait_rise(lat);
    check("pre_reset_latency", lat, 7);
    reset = 1;
    tick();
    check("midrst_key", key, 0);
    check("midrst_wait", wait_lamp, 0);
    check("midrst_timeout", timeout, 0);
    reset = 0; btn_raw = 0;
`ifdef PED_REQ_COUNT_EN
    check("count_after_reset", req_count, 0);
`endif
    ticks(4);

    for (int i = 0; i < 3; i++) serve_one();
`ifdef PED_REQ_COUNT_EN
    check("count_three", req_count, 3);
`endif

    // Randomized button and lamp traffic with rare resets.
    btn_hold = 0; lamp_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (btn_hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        btn_hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 30));
      end
      btn_hold--;
      if (lamp_hold == 0) begin
        pick = int'($urandom_range(0, 9));
        if (pick <= 5) begin red = 1; green = 0; end
        else if (pick <= 7) begin red = 0; green = 1; end
        else if (pick == 8) begin red = 1; green = 1; end
        else begin red = 0; green = 0; end
        lamp_hold = int'($urandom_range(1, 40));
      end
      lamp_hold--;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ped_request_unit.md
Name: ped_request_unit

Overview:
Pedestrian-side initiator for the crossing light controller. It turns a raw, bouncy pedestrian push-button into a clean, held `key` request. It watches the controller's `red`/`green` lamps to know when the request has been served, then drops `key`. It sits between the kerbside button/lamp panel and the light controller's `key` input.

Parameters:
- DEBOUNCE_CYCLES, 4, clock cycles the synchronised button must stay high before a request is raised (>=1).
- TIMEOUT_CYCLES, 64, max cycles `key` stays asserted without a grant before the request is abandoned (>=2).
- HOLDOFF_CYCLES, 8, cycles after the green phase ends during which new presses are ignored (>=1).
- CNT_W, 8, counter width; must hold max(DEBOUNCE_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES).

Ports:
- clock  input  1  single system clock, rising edge only
- reset  input  1  synchronous, active-high reset
- btn_raw  input  1  asynchronous raw push-button, 1 = pressed
- red  input  1  controller red lamp
- green  input  1  controller green lamp
- key  output  1  crossing request to controller, level, registered
- wait_lamp  output  1  "WAIT" indicator, high while a request is pending
- timeout  output  1  one-cycle pulse when a request is abandoned
- lamp_fault  output  1  one-cycle pulse per cycle with red==green while in REQ or GRANT

Behaviour:
- Reset: synchronous, checked on the rising edge of `clock`; active-high. It forces state IDLE, all counters 0, `armed`=1, synchroniser flops 0. All outputs reset to 0.
- Reset mid-operation drops `key` on the next edge; no pulse outputs fire.
- Input path:
  - `btn_raw` passes through a 2-flop synchroniser giving `btn_s`, 2 cycles of latency.
  - `armed` clears on entry to REQ and sets again whenever `btn_s`==0.
  - A held button therefore cannot raise a second request.
- FSM states: IDLE, DEBOUNCE, REQ, GRANT, HOLDOFF.
- IDLE:
  - key=0, wait_lamp=0.
  - If `btn_s`&`armed`, go to DEBOUNCE and load cnt=DEBOUNCE_CYCLES-1.
- DEBOUNCE:
  - If `btn_s`==0, go to IDLE.
  - Else if cnt==0, go to REQ and load cnt=TIMEOUT_CYCLES-1.
  - Else cnt decrements.
  - Latency from a clean press to key=1 is 2+DEBOUNCE_CYCLES+1 cycles.
- REQ:
  - key=1, wait_lamp=1; the button is ignored.
  - green=1 & red=0 means granted: go to GRANT.
  - Else if cnt==0, pulse `timeout` and go to IDLE with key=0.
  - Else cnt decrements.
  - The grant takes priority over timeout when both occur in the same cycle.
- GRANT:
  - key=0, wait_lamp=0.
  - When red=1 & green=0, go to HOLDOFF and load cnt=HOLDOFF_CYCLES-1.
  - GRANT has no timeout; the controller owns the green duration.
- HOLDOFF:
  - key=0; presses are ignored.
  - When cnt==0, go to IDLE; else cnt decrements.
- Lamp fault: red==green (both 0 or both 1) in REQ or GRANT raises `lamp_fault` for that cycle and is not a grant or a release. The state is held, and the REQ timeout keeps counting.
- Counter: one shared CNT_W-bit down-counter, reloaded on every state entry. It never wraps below 0.
- `key` and `wait_lamp` are registered (Moore outputs). `timeout` and `lamp_fault` are registered one-cycle pulses.

Optional Feature:
- Macro: PED_REQ_COUNT_EN.
- When defined:
  - Adds output port `req_count [15:0]`, which increments by 1 on each REQ->GRANT transition.
  - It saturates at 16'hFFFF and resets to 0.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package ped_req_pkg holds:
  - the state encoding constants: IDLE=3'd0, DEBOUNCE=3'd1, REQ=3'd2, GRANT=3'd3, HOLDOFF=3'd4;
  - the default parameter values;
  - the req_count width 16.
- Sub-module ped_btn_sync holds the 2-flop synchroniser plus the `armed` release tracker. Its outputs are `btn_s` and `armed`.
- The FSM and the counter stay in ped_request_unit.

Test Plan:
- Clean press: btn_raw=1 held 20 cycles, red=1 green=0 → key rises at cycle 7 after the press edge (defaults) and wait_lamp=1; green=1 red=0 for 10 cycles → key=0 on the next edge; then red=1 → HOLDOFF for 8 cycles → IDLE. No second request while the button is still held.
- Bounce: btn_raw toggles 1,0,1,0 on single cycles, then stays 0 → key never asserts and the state returns to IDLE.
- Timeout: press, then keep red=1 green=0 → key high exactly 64 cycles; timeout pulses once; key=0; a re-press after release raises key again.
- Release/re-arm: btn_raw held high through a full grant cycle → exactly one request. Release then press again → a new request after the debounce latency.
- Lamp fault: in REQ drive red=green=1 for 3 cycles → lamp_fault high 3 cycles, key stays 1, no grant. In GRANT drive red=green=0 → lamp_fault pulses and the state stays GRANT.
- Reset mid-REQ: reset=1 for 1 cycle while key=1 → key=0 and wait_lamp=0 on the next edge, no timeout pulse. With PED_REQ_COUNT_EN, req_count=0 after reset and equals 3 after three served requests.
